cla_pipe_adder: RTL
===================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is split into GROUP-bit lookahead groups, and each group is resolved in its own pipeline stage. A ripple-free group carry is registered into the next stage. The block sits in the datapath as a streaming arithmetic unit behind a valid/ready handshake, and accepts one operation per cycle.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of GROUP, ≥ GROUP
- GROUP, 4, bits per lookahead group = bits resolved per pipeline stage
- Derived: NSTG = WIDTH/GROUP (pipeline depth)

- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation present on inputs
- in_ready  output  1  block accepts operation this cycle
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- c_in  input  1  carry-in (add mode only)
- sub  input  1  0: A+B+c_in; 1: A−B (A+~B+1, c_in ignored)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result bits
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation
- Per group k (bits k·GROUP … k·GROUP+GROUP−1): p = a ^ b', g = a & b'. b' = sub ? ~b_in : b_in.
- Group sum bits and group carry-out are computed with full lookahead from the registered group carry-in. There is no intra-group ripple chain.
- Stage 0 carry-in = sub ? 1 : c_in.
- Stage k computes group k. Its carry-out is registered as stage k+1's carry-in.
- Operand bits of groups > k are carried forward in skew registers. Sum bits of groups < k are carried forward in de-skew registers.
- cout = carry-out of group NSTG−1.
- ovf = carry into MSB XOR carry out of MSB. This equals (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).
- Each stage holds one valid bit. A transfer occurs when in_valid && in_ready.
- Global stall: adv = !out_valid || out_ready. When adv=1, all stages shift by one. When adv=0, all stage registers hold.
- in_ready = adv (combinational from out_valid register and out_ready).
- Bubbles travel with valid=0. Bubbles are not collapsed.
- Results leave in acceptance order; none are dropped or duplicated.
- Output registers (sum, cout, ovf) update only when adv=1 and the last stage holds valid data. Otherwise they retain their value.

## Timing
- Reset (rst=1 at clock edge): all stage valid bits cleared, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards every in-flight operation. No result for it ever appears.
- Latency: an operation accepted at edge t produces out_valid=1 after edge t+NSTG with no stall (NSTG=4 for defaults).
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle of latency to every in-flight operation.
- Throughput: 1 op/cycle while out_ready=1.
- Simultaneous accept and drain in the same cycle is allowed and required: a full pipe with out_ready=1 keeps in_ready=1.
- Stall hold: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid are stable. Inputs presented with in_valid=1 are not accepted (in_ready=0).
- Combinational depth per stage: one GROUP-bit lookahead plus output mux. There is no path spanning more than one group.

## Test plan
Defaults (WIDTH=16, GROUP=4, NSTG=4).
- Add, carry through all groups: a=0xFFFF, b=0x0001, c_in=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, cout=0, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, c_in=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: 6 back-to-back ops (a=i, b=0x0100·i, i=1..6), out_ready=0 for 3 cycles once the first result appears.
  - Required: in_ready=0 throughout the stall.
  - Outputs held stable during the stall.
  - All 6 results delivered in order with sum=0x0101·i.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle at the edge after the 3rd.
  - Required: out_valid=0, sum=0, cout=0, ovf=0 after that edge.
  - None of the 3 results ever appears.
  - in_ready=1 the cycle after reset.
- Random regression: 10k random a/b/c_in/sub with random in_valid/out_ready, compared against a behavioural model. Checks sum/cout/ovf, ordering, and a count of exactly one result per accepted op.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// Each stage resolves one GROUP-bit lookahead group and registers its carry into the next stage.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / GROUP;
  localparam int LAST = NSTG - 1;

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  stg_t             stg_q [NSTG];
  stg_t             stg_d [NSTG];
  logic [WIDTH-1:0] grp_s;
  logic [NSTG-1:0]  grp_co;
  logic [WIDTH-1:0] res;
  logic             adv;

  // Every carry of the group is a flat sum of generate/propagate
  // products from the group carry-in, so no bit waits on its neighbour.
  function automatic logic [GROUP:0] cla(
    input logic [GROUP-1:0] p,
    input logic [GROUP-1:0] g,
    input logic             ci
  );
    logic [GROUP:0] cy;
    logic           t;
    for (int i = 0; i <= GROUP; i++) begin
      t = ci;
      for (int j = 0; j < i; j++) t = t & p[j];
      cy[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        cy[i] = cy[i] | t;
      end
    end
    return cy;
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_grp
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   cy;
    assign p = stg_q[k].a[k*GROUP +: GROUP]
             ^ stg_q[k].b[k*GROUP +: GROUP];
    assign g = stg_q[k].a[k*GROUP +: GROUP]
             & stg_q[k].b[k*GROUP +: GROUP];
    assign cy = cla(p, g, stg_q[k].c);
    assign grp_s[k*GROUP +: GROUP] = p ^ cy[GROUP-1:0];
    assign grp_co[k] = cy[GROUP];
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Next-stage contents: capture at stage 0, then each stage
  // forwards operands, drops in its group sum and carry.
  always_comb begin
    stg_d[0]   = '0;
    stg_d[0].v = in_valid;
    stg_d[0].a = a_in;
    stg_d[0].b = sub ? ~b_in : b_in;
    stg_d[0].c = sub | c_in;
    for (int k = 1; k < NSTG; k++) begin
      stg_d[k]   = stg_q[k-1];
      stg_d[k].c = grp_co[k-1];
      stg_d[k].s[(k-1)*GROUP +: GROUP] =
        grp_s[(k-1)*GROUP +: GROUP];
    end
  end

  // Full result: de-skewed low groups plus the last stage's group.
  always_comb begin
    res = stg_q[LAST].s;
    res[LAST*GROUP +: GROUP] = grp_s[LAST*GROUP +: GROUP];
  end

  // Stage registers shift together on adv and hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) stg_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) stg_q[k] <= stg_d[k];
    end
  end

  // Output register: takes a result only when it moves and is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= stg_q[LAST].v;
      if (stg_q[LAST].v) begin
        sum  <= res;
        cout <= grp_co[LAST];
        ovf  <= (stg_q[LAST].a[WIDTH-1] == stg_q[LAST].b[WIDTH-1])
             && (res[WIDTH-1] != stg_q[LAST].a[WIDTH-1]);
      end
    end
  end

endmodule
